mcpu_ctrl: RTL and testbench
============================

Name: mcpu_ctrl

Overview:
Multicycle CPU control unit. A Moore FSM sequences the datapath's 32-bit clock-enabled registers (PC, IR, MDR, A/B, ALUOut) and drives the mux selects, ALU operation, and memory read/write strobes. It sits between the instruction register and the datapath, and handshakes with memory through mem_ready.

Parameters:
MEM_HANDSHAKE, 1, 1 = wait states honour mem_ready; 0 = mem_ready is treated as constant 1 (single-cycle memory).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
opcode  in  6  IR[31:26].
funct  in  6  IR[5:0].
zero  in  1  ALU zero flag.
mem_ready  in  1  memory access complete this cycle.
pc_ce  out  1  PC register enable.
ir_ce  out  1  IR enable.
mdr_ce  out  1  MDR enable.
ab_ce  out  1  A/B register enable.
aluout_ce  out  1  ALUOut enable.
reg_wr  out  1  register-file write.
mem_rd  out  1  memory read strobe.
mem_wr  out  1  memory write strobe.
iord  out  1  address select: 0 = PC, 1 = ALUOut.
alu_src_a  out  1  0 = PC, 1 = A.
alu_src_b  out  2  00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2.
ext_zero  out  1  1 = zero-extend imm (andi, ori); 0 = sign-extend.
alu_ctrl  out  3  AND 000, OR 001, ADD 010, XOR 011, NOR 100, SRL 101, SUB 110, SLT 111.
pc_src  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = trap vector.
reg_dst  out  2  00 = rt, 01 = rd, 10 = r31.
mem_to_reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC.
state  out  4  current state, for debug.

Behaviour:
- Reset: with rst_n low at a rising edge, state <= IF. While rst_n is low, all enables and strobes (pc_ce, ir_ce, mdr_ce, ab_ce, aluout_ce, reg_wr, mem_rd, mem_wr) are forced to 0 and every select output is 0. Reset mid-instruction abandons the instruction; no partial writes occur after the reset edge.
- Outputs are combinational from state, plus mem_ready/zero where listed. Unlisted outputs are 0.
- IF: mem_rd = 1, alu_src_b = 01, ADD. ir_ce and pc_ce = mem_ready. Stay in IF while mem_ready = 0; go to ID otherwise.
- ID: ab_ce = 1, aluout_ce = 1, alu_src_b = 11, ADD (branch target). Decode:
  - R-type (0x00) -> EX_R.
  - lw (0x23) and sw (0x2B) -> MEM_ADDR.
  - beq (0x04) and bne (0x05) -> BR.
  - addi (0x08), slti (0x0A), andi (0x0C), ori (0x0D) -> EX_I.
  - j (0x02) and jal (0x03) -> JMP.
  - Anything else -> ILLEGAL handling (see Optional Feature).
- EX_R: alu_src_a = 1, alu_src_b = 00, aluout_ce = 1. alu_ctrl from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x02 SRL. Next state WB_R.
- WB_R: reg_wr = 1, reg_dst = 01. Next state IF.
- EX_I: alu_src_a = 1, alu_src_b = 10, aluout_ce = 1. ALU op: addi ADD, slti SLT, andi AND, ori OR. ext_zero = 1 for andi/ori. Next state WB_I.
- WB_I: reg_wr = 1, reg_dst = 00. Next state IF.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, ADD, aluout_ce = 1. Next state MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_rd = 1, iord = 1, mdr_ce = mem_ready. Wait while mem_ready = 0, then WB_LW.
- MEM_WR: mem_wr = 1, iord = 1. Wait while mem_ready = 0, then IF.
- WB_LW: reg_wr = 1, mem_to_reg = 01. Next state IF.
- BR: alu_src_a = 1, SUB, pc_src = 01. pc_ce = zero for beq, !zero for bne. Next state IF.
- JMP: pc_src = 10, pc_ce = 1. For jal, also reg_wr = 1, reg_dst = 10, mem_to_reg = 10. Next state IF.
- Cycle counts with zero wait states: R/I-type 4, lw 5, sw 4, branch 3, jump 3. Each mem_ready = 0 cycle adds exactly one cycle.
- Unknown funct under R-type is handled as an illegal instruction.
- Undefined state encodings go to IF.

Optional Feature:
MCPU_ILLEGAL_TRAP_EN.
- Defined: illegal opcode/funct goes from ID to TRAP. TRAP sets pc_src = 11, pc_ce = 1, and a one-cycle output `illegal` = 1, then goes to IF.
- Undefined: illegal instructions go ID -> IF as a NOP (3 cycles incl. IF is wrong; it is 2 cycles: IF, ID). No `illegal` port exists and the TRAP state is absent.

Decomposition:
- Package mcpu_ctrl_pkg holds: state encoding, opcode/funct constants, alu_ctrl codes, and the alu_src_b/pc_src/reg_dst/mem_to_reg select codes.
- One sub-module, mcpu_alu_dec: combinational (state class, opcode, funct) -> alu_ctrl and ext_zero.

Test Plan:
- Release rst_n, hold mem_ready = 1 -> first cycle in IF with mem_rd = 1, ir_ce = pc_ce = 1. Assert rst_n = 0 in WB_R -> reg_wr = 0 and state = IF on the next edge.
- R-type add (opcode 0x00, funct 0x20) -> states IF, ID, EX_R, WB_R; alu_ctrl = 010 in EX_R; reg_wr = 1 with reg_dst = 01 only in WB_R.
- lw (0x23) with mem_ready low for 2 cycles in MEM_RD -> 7 cycles total; mdr_ce pulses exactly once; mem_to_reg = 01 in WB_LW.
- beq with zero = 1 then zero = 0 -> pc_ce = 1 then 0 in BR. bne inverts this.
- jal (0x03) -> JMP with pc_src = 10, reg_dst = 10, mem_to_reg = 10, reg_wr = 1.
- Opcode 0x3F -> with MCPU_ILLEGAL_TRAP_EN: TRAP, pc_src = 11, illegal = 1 for one cycle. Without it: ID -> IF, no writes.

Source files
------------

// File: rtl/mcpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control unit: FSM states, opcode/funct
// values, ALU operation codes and datapath mux select codes.
package mcpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EX_R     = 4'd2,
    S_WB_R     = 4'd3,
    S_EX_I     = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_LW    = 4'd9,
    S_BR       = 4'd10,
    S_JMP      = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  // Which rule the ALU decoder applies in the current state.
  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_ADD   = 3'd1,
    CLS_SUB   = 3'd2,
    CLS_RTYPE = 3'd3,
    CLS_ITYPE = 3'd4
  } alu_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ASB_B       = 2'b00;
  localparam logic [1:0] ASB_FOUR    = 2'b01;
  localparam logic [1:0] ASB_IMM     = 2'b10;
  localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_TRAP   = 2'b11;

  localparam logic [1:0] RDST_RT  = 2'b00;
  localparam logic [1:0] RDST_RD  = 2'b01;
  localparam logic [1:0] RDST_R31 = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  function automatic logic funct_legal(input logic [5:0] funct);
    logic ok;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SRL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // An R-type word is only legal when its funct is one we can execute.
  function automatic logic insn_legal(input logic [5:0] opcode, input logic [5:0] funct);
    logic ok;
    case (opcode)
      OP_RTYPE: ok = funct_legal(funct);
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
      OP_J, OP_JAL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mcpu_alu_dec.sv
// ALU operation decoder: maps the state's ALU rule plus opcode/funct to the
// 3-bit ALU control code and the immediate extension mode.
module mcpu_alu_dec
  import mcpu_ctrl_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       ext_zero_o
);

  always_comb begin
    alu_ctrl_o = ALU_AND;
    ext_zero_o = 1'b0;
    case (cls_i)
      CLS_ADD: alu_ctrl_o = ALU_ADD;
      CLS_SUB: alu_ctrl_o = ALU_SUB;
      CLS_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_XOR:  alu_ctrl_o = ALU_XOR;
          FN_NOR:  alu_ctrl_o = ALU_NOR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          FN_SRL:  alu_ctrl_o = ALU_SRL;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      CLS_ITYPE: begin
        // Logical immediates take a zero-extended operand, arithmetic ones sign-extended.
        case (opcode_i)
          OP_ADDI: alu_ctrl_o = ALU_ADD;
          OP_SLTI: alu_ctrl_o = ALU_SLT;
          OP_ANDI: begin
            alu_ctrl_o = ALU_AND;
            ext_zero_o = 1'b1;
          end
          OP_ORI: begin
            alu_ctrl_o = ALU_OR;
            ext_zero_o = 1'b1;
          end
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      default: alu_ctrl_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multicycle CPU control unit: Moore FSM driving datapath enables, selects and
// memory strobes. Define MCPU_ILLEGAL_TRAP_EN to add the TRAP state and `illegal` port.
module mcpu_ctrl
  import mcpu_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_ce,
  output logic       ir_ce,
  output logic       mdr_ce,
  output logic       ab_ce,
  output logic       aluout_ce,
  output logic       reg_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [3:0] state
`ifdef MCPU_ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  state_e   state_q;
  state_e   state_d;
  alu_cls_e alu_cls;
  logic     mem_ok;
  logic     legal;

  assign mem_ok = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign legal  = insn_legal(opcode, funct);
  assign state  = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: begin
        if (mem_ok) state_d = S_ID;
        else        state_d = S_IF;
      end
      S_ID: begin
        if (!legal) begin
`ifdef MCPU_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_IF;
`endif
        end else begin
          case (opcode)
            OP_RTYPE:                         state_d = S_EX_R;
            OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE:                   state_d = S_BR;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EX_I;
            OP_J, OP_JAL:                     state_d = S_JMP;
            default:                          state_d = S_IF;
          endcase
        end
      end
      S_EX_R: state_d = S_WB_R;
      S_EX_I: state_d = S_WB_I;
      S_MEM_ADDR: begin
        if (opcode == OP_LW) state_d = S_MEM_RD;
        else                 state_d = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ok) state_d = S_WB_LW;
        else        state_d = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ok) state_d = S_IF;
        else        state_d = S_MEM_WR;
      end
      default: state_d = S_IF;
    endcase
  end

  // Reset forces every enable, strobe and select low regardless of state_q.
  always_comb begin
    pc_ce      = 1'b0;
    ir_ce      = 1'b0;
    mdr_ce     = 1'b0;
    ab_ce      = 1'b0;
    aluout_ce  = 1'b0;
    reg_wr     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ASB_B;
    pc_src     = PCS_ALU;
    reg_dst    = RDST_RT;
    mem_to_reg = M2R_ALUOUT;
    alu_cls    = CLS_NONE;
`ifdef MCPU_ILLEGAL_TRAP_EN
    illegal    = 1'b0;
`endif
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          mem_rd    = 1'b1;
          alu_src_b = ASB_FOUR;
          alu_cls   = CLS_ADD;
          ir_ce     = mem_ok;
          pc_ce     = mem_ok;
        end
        S_ID: begin
          ab_ce     = 1'b1;
          aluout_ce = 1'b1;
          alu_src_b = ASB_IMM_SH2;
          alu_cls   = CLS_ADD;
        end
        S_EX_R: begin
          alu_src_a = 1'b1;
          alu_src_b = ASB_B;
          aluout_ce = 1'b1;
          alu_cls   = CLS_RTYPE;
        end
        S_WB_R: begin
          reg_wr  = 1'b1;
          reg_dst = RDST_RD;
        end
        S_EX_I: begin
          alu_src_a = 1'b1;
          alu_src_b = ASB_IMM;
          aluout_ce = 1'b1;
          alu_cls   = CLS_ITYPE;
        end
        S_WB_I: begin
          reg_wr  = 1'b1;
          reg_dst = RDST_RT;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = ASB_IMM;
          aluout_ce = 1'b1;
          alu_cls   = CLS_ADD;
        end
        S_MEM_RD: begin
          mem_rd = 1'b1;
          iord   = 1'b1;
          mdr_ce = mem_ok;
        end
        S_MEM_WR: begin
          mem_wr = 1'b1;
          iord   = 1'b1;
        end
        S_WB_LW: begin
          reg_wr     = 1'b1;
          mem_to_reg = M2R_MDR;
        end
        S_BR: begin
          // A - B through the ALU; the branch target was parked in ALUOut during ID.
          alu_src_a = 1'b1;
          alu_cls   = CLS_SUB;
          pc_src    = PCS_ALUOUT;
          if (opcode == OP_BNE) pc_ce = ~zero;
          else                  pc_ce = zero;
        end
        S_JMP: begin
          pc_src = PCS_JUMP;
          pc_ce  = 1'b1;
          if (opcode == OP_JAL) begin
            reg_wr     = 1'b1;
            reg_dst    = RDST_R31;
            mem_to_reg = M2R_PC;
          end else begin
            reg_wr = 1'b0;
          end
        end
`ifdef MCPU_ILLEGAL_TRAP_EN
        S_TRAP: begin
          pc_src  = PCS_TRAP;
          pc_ce   = 1'b1;
          illegal = 1'b1;
        end
`endif
        default: alu_cls = CLS_NONE;
      endcase
    end else begin
      alu_cls = CLS_NONE;
    end
  end

  mcpu_alu_dec u_alu_dec (
    .cls_i      (alu_cls),
    .opcode_i   (opcode),
    .funct_i    (funct),
    .alu_ctrl_o (alu_ctrl),
    .ext_zero_o (ext_zero)
  );

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Self-checking bench for mcpu_ctrl: directed scenarios plus a randomized
// instruction stream checked against a per-instruction phase model.
`timescale 1ns/1ps
module tb_mcpu_ctrl;
  import mcpu_ctrl_pkg::*;

  typedef struct packed {
    logic       pc_ce;
    logic       ir_ce;
    logic       mdr_ce;
    logic       ab_ce;
    logic       aluout_ce;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       illegal;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       pc_ce, ir_ce, mdr_ce, ab_ce, aluout_ce, reg_wr, mem_rd, mem_wr, iord, alu_src_a;
  logic [1:0] alu_src_b, pc_src, reg_dst, mem_to_reg;
  logic       ext_zero;
  logic [2:0] alu_ctrl;
  logic [3:0] state;
  logic       illegal_s;
  outs_t      obs;

  int checks = 0;
  int failures = 0;
  int n_mdr = 0, n_regwr = 0, n_pcce = 0, n_memwr = 0, n_ill = 0;
  logic [3:0] bad_state, bad_exp_state;
  outs_t      bad_obs, bad_exp;
  state_e     plan[$];

  logic [5:0] legal_ops [12] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
                                 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h02, 6'h03};
  logic [5:0] legal_fns [8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02};

  always #5 clk = ~clk;

  mcpu_ctrl #(.MEM_HANDSHAKE(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_ce(pc_ce), .ir_ce(ir_ce), .mdr_ce(mdr_ce), .ab_ce(ab_ce),
    .aluout_ce(aluout_ce), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_ctrl(alu_ctrl),
    .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .state(state)
`ifdef MCPU_ILLEGAL_TRAP_EN
    , .illegal(illegal_s)
`endif
  );
`ifndef MCPU_ILLEGAL_TRAP_EN
  assign illegal_s = 1'b0;
`endif

  assign obs = {pc_ce, ir_ce, mdr_ce, ab_ce, aluout_ce, reg_wr, mem_rd, mem_wr, iord,
                alu_src_a, alu_src_b, ext_zero, alu_ctrl, pc_src, reg_dst, mem_to_reg, illegal_s};

  function automatic logic op_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02};
    return op inside {6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h02, 6'h03};
  endfunction

  // Zero-wait cycle count of one instruction, straight from the timing table.
  function automatic int spec_cycles(input logic [5:0] op, input logic [5:0] fn);
    if (!op_legal(op, fn)) begin
`ifdef MCPU_ILLEGAL_TRAP_EN
      return 3;
`else
      return 2;
`endif
    end
    if (op == 6'h23) return 5;
    if (op inside {6'h04, 6'h05, 6'h02, 6'h03}) return 3;
    return 4;
  endfunction

  function automatic void make_plan(input logic [5:0] op, input logic [5:0] fn);
    plan.delete();
    plan.push_back(S_IF);
    plan.push_back(S_ID);
    if (!op_legal(op, fn)) begin
`ifdef MCPU_ILLEGAL_TRAP_EN
      plan.push_back(S_TRAP);
`endif
    end else if (op == 6'h00) begin
      plan.push_back(S_EX_R); plan.push_back(S_WB_R);
    end else if (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D}) begin
      plan.push_back(S_EX_I); plan.push_back(S_WB_I);
    end else if (op == 6'h23) begin
      plan.push_back(S_MEM_ADDR); plan.push_back(S_MEM_RD); plan.push_back(S_WB_LW);
    end else if (op == 6'h2B) begin
      plan.push_back(S_MEM_ADDR); plan.push_back(S_MEM_WR);
    end else if (op inside {6'h04, 6'h05}) begin
      plan.push_back(S_BR);
    end else begin
      plan.push_back(S_JMP);
    end
  endfunction

  function automatic outs_t exp_outs(input state_e ph, input logic [5:0] op, input logic [5:0] fn,
                                     input logic z, input logic mr);
    outs_t o = '0;
    case (ph)
      S_IF:       begin o.mem_rd = 1'b1; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010;
                        o.ir_ce = mr; o.pc_ce = mr; end
      S_ID:       begin o.ab_ce = 1'b1; o.aluout_ce = 1'b1; o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010; end
      S_EX_R: begin
        o.alu_src_a = 1'b1; o.aluout_ce = 1'b1;
        case (fn)
          6'h20: o.alu_ctrl = 3'b010;  6'h22: o.alu_ctrl = 3'b110;
          6'h24: o.alu_ctrl = 3'b000;  6'h25: o.alu_ctrl = 3'b001;
          6'h26: o.alu_ctrl = 3'b011;  6'h27: o.alu_ctrl = 3'b100;
          6'h2A: o.alu_ctrl = 3'b111;  6'h02: o.alu_ctrl = 3'b101;
          default: o.alu_ctrl = 3'b000;
        endcase
      end
      S_WB_R:     begin o.reg_wr = 1'b1; o.reg_dst = 2'b01; end
      S_EX_I: begin
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.aluout_ce = 1'b1;
        o.alu_ctrl = (op == 6'h08) ? 3'b010 : (op == 6'h0A) ? 3'b111 : (op == 6'h0C) ? 3'b000 : 3'b001;
        o.ext_zero = (op == 6'h0C) || (op == 6'h0D);
      end
      S_WB_I:     o.reg_wr = 1'b1;
      S_MEM_ADDR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; o.aluout_ce = 1'b1; end
      S_MEM_RD:   begin o.mem_rd = 1'b1; o.iord = 1'b1; o.mdr_ce = mr; end
      S_MEM_WR:   begin o.mem_wr = 1'b1; o.iord = 1'b1; end
      S_WB_LW:    begin o.reg_wr = 1'b1; o.mem_to_reg = 2'b01; end
      S_BR:       begin o.alu_src_a = 1'b1; o.alu_ctrl = 3'b110; o.pc_src = 2'b01;
                        o.pc_ce = (op == 6'h04) ? z : !z; end
      S_JMP: begin
        o.pc_src = 2'b10; o.pc_ce = 1'b1;
        if (op == 6'h03) begin o.reg_wr = 1'b1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; end
      end
      S_TRAP:     begin o.pc_src = 2'b11; o.pc_ce = 1'b1; o.illegal = 1'b1; end
      default:    o = '0;
    endcase
    return o;
  endfunction

  function automatic string trace_msg(input int nbad);
    return $sformatf("bad_cycles=%0d first: state=%0d required_state=%0d outs=%h required_outs=%h",
                     nbad, bad_state, bad_exp_state, bad_obs, bad_exp);
  endfunction

  // Runs one instruction from IF until the DUT comes back to IF (bounded), checking every cycle
  // against the phase plan. waits<0: random mem_ready; waits>=0: exactly that many waits in MEM_RD/WR.
  task automatic run_insn(input logic [5:0] op, input logic [5:0] fn, input int zsel, input int waits,
                          output int ncyc, output int nbad, output int nwait);
    int     idx, wcnt;
    logic   left, mr, z, waitable;
    outs_t  e;
    make_plan(op, fn);
    idx = 0; wcnt = 0; left = 1'b0; ncyc = 0; nbad = 0; nwait = 0;
    while (ncyc < 40) begin
      @(negedge clk);
      if (ncyc == 0) begin opcode = op; funct = fn; end
      if (zsel == 2) z = ($urandom_range(0, 1) == 1);
      else           z = (zsel == 1);
      waitable = (idx < plan.size()) && (plan[idx] inside {S_IF, S_MEM_RD, S_MEM_WR});
      if (waitable) begin
        if (waits < 0)              mr = (wcnt >= 3) || ($urandom_range(0, 1) == 1);
        else if (plan[idx] == S_IF) mr = 1'b1;
        else                        mr = (wcnt >= waits);
      end else begin
        mr = (waits < 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      mem_ready = mr; zero = z;
      #1;
      e = '0;
      if (idx < plan.size()) e = exp_outs(plan[idx], op, fn, z, mr);
      if (idx >= plan.size() || state !== plan[idx] || obs !== e) begin
        if (nbad == 0) begin
          bad_state = state; bad_obs = obs; bad_exp = e;
          bad_exp_state = (idx < plan.size()) ? plan[idx] : 4'hF;
        end
        nbad++;
      end
      if (mdr_ce === 1'b1) n_mdr++;
      if (reg_wr === 1'b1) n_regwr++;
      if (pc_ce === 1'b1) n_pcce++;
      if (mem_wr === 1'b1) n_memwr++;
      if (illegal_s === 1'b1) n_ill++;
      if (waitable && !mr) begin wcnt++; nwait++; end
      else begin idx++; wcnt = 0; end
      ncyc++;
      if (state !== S_IF) left = 1'b1;
      @(posedge clk); #1;
      if (left && state === S_IF) break;
    end
  endtask

  task automatic test_reset();
    outs_t e;
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = 6'h00; funct = 6'h20;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_outs outs=%h required=%h", obs, 23'h0); end
    checks++;
    if (state !== S_IF) begin failures++; $display("FAIL reset_state state=%0d required=%0d", state, S_IF); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); #1;
    e = exp_outs(S_IF, 6'h00, 6'h20, 1'b0, 1'b1);
    checks++;
    if (obs !== e || state !== S_IF)
      begin failures++; $display("FAIL first_if state=%0d outs=%h required=%h", state, obs, e); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (state !== S_WB_R || reg_wr !== 1'b1)
      begin failures++; $display("FAIL wbr_before_reset state=%0d reg_wr=%b required WB_R/1", state, reg_wr); end
    rst_n = 1'b0; #1;
    checks++;
    if (obs !== '0) begin failures++; $display("FAIL reset_mid_outs outs=%h required=%h", obs, 23'h0); end
    @(posedge clk); #1;
    checks++;
    if (state !== S_IF) begin failures++; $display("FAIL reset_mid_state state=%0d required=%0d", state, S_IF); end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype_add();
    int ncyc, nbad, nw, r0;
    r0 = n_regwr;
    run_insn(6'h00, 6'h20, 2, 0, ncyc, nbad, nw);
    checks++;
    if (nbad !== 0) begin failures++; $display("FAIL rtype_add_trace %s", trace_msg(nbad)); end
    checks++;
    if (ncyc !== 4) begin failures++; $display("FAIL rtype_add_cycles got=%0d required=4", ncyc); end
    checks++;
    if (n_regwr - r0 !== 1) begin failures++; $display("FAIL rtype_add_regwr got=%0d required=1", n_regwr - r0); end
  endtask

  task automatic test_lw_wait();
    int ncyc, nbad, nw, m0, r0;
    m0 = n_mdr; r0 = n_regwr;
    run_insn(6'h23, 6'h00, 2, 2, ncyc, nbad, nw);
    checks++;
    if (nbad !== 0) begin failures++; $display("FAIL lw_wait_trace %s", trace_msg(nbad)); end
    checks++;
    if (ncyc !== 7) begin failures++; $display("FAIL lw_wait_cycles got=%0d required=7", ncyc); end
    checks++;
    if (n_mdr - m0 !== 1) begin failures++; $display("FAIL lw_mdr_pulses got=%0d required=1", n_mdr - m0); end
    checks++;
    if (n_regwr - r0 !== 1) begin failures++; $display("FAIL lw_regwr got=%0d required=1", n_regwr - r0); end
  endtask

  task automatic test_branch();
    int ncyc, nbad, nw, p0, taken;
    logic [5:0] op;
    for (int k = 0; k < 4; k++) begin
      op = (k < 2) ? 6'h04 : 6'h05;
      taken = (op == 6'h04) ? ((k % 2) == 0) : ((k % 2) == 1);
      p0 = n_pcce;
      run_insn(op, 6'h00, (k % 2 == 0) ? 1 : 0, 0, ncyc, nbad, nw);
      checks++;
      if (nbad !== 0) begin failures++; $display("FAIL branch%0d_trace %s", k, trace_msg(nbad)); end
      checks++;
      if (ncyc !== 3) begin failures++; $display("FAIL branch%0d_cycles got=%0d required=3", k, ncyc); end
      checks++;
      if (n_pcce - p0 !== 1 + taken)
        begin failures++; $display("FAIL branch%0d_pcce got=%0d required=%0d", k, n_pcce - p0, 1 + taken); end
    end
  endtask

  task automatic test_jump();
    int ncyc, nbad, nw, r0;
    for (int k = 0; k < 2; k++) begin
      r0 = n_regwr;
      run_insn((k == 0) ? 6'h03 : 6'h02, 6'h00, 2, 0, ncyc, nbad, nw);
      checks++;
      if (nbad !== 0) begin failures++; $display("FAIL jump%0d_trace %s", k, trace_msg(nbad)); end
      checks++;
      if (ncyc !== 3) begin failures++; $display("FAIL jump%0d_cycles got=%0d required=3", k, ncyc); end
      checks++;
      if (n_regwr - r0 !== ((k == 0) ? 1 : 0))
        begin failures++; $display("FAIL jump%0d_regwr got=%0d", k, n_regwr - r0); end
    end
  endtask

  task automatic test_illegal();
    int ncyc, nbad, nw, w0, i0, want_cyc, want_ill;
`ifdef MCPU_ILLEGAL_TRAP_EN
    want_cyc = 3; want_ill = 1;
`else
    want_cyc = 2; want_ill = 0;
`endif
    for (int k = 0; k < 2; k++) begin
      w0 = n_regwr + n_memwr; i0 = n_ill;
      run_insn((k == 0) ? 6'h3F : 6'h00, (k == 0) ? 6'h20 : 6'h3F, 2, 0, ncyc, nbad, nw);
      checks++;
      if (nbad !== 0) begin failures++; $display("FAIL illegal%0d_trace %s", k, trace_msg(nbad)); end
      checks++;
      if (ncyc !== want_cyc) begin failures++; $display("FAIL illegal%0d_cycles got=%0d required=%0d", k, ncyc, want_cyc); end
      checks++;
      if (n_regwr + n_memwr - w0 !== 0) begin failures++; $display("FAIL illegal%0d_writes got=%0d required=0", k, n_regwr + n_memwr - w0); end
      checks++;
      if (n_ill - i0 !== want_ill) begin failures++; $display("FAIL illegal%0d_flag got=%0d required=%0d", k, n_ill - i0, want_ill); end
    end
  endtask

  task automatic test_back_to_back();
    int ncyc, nbad, nw;
    run_insn(6'h2B, 6'h00, 2, 1, ncyc, nbad, nw);
    checks++;
    if (nbad !== 0 || ncyc !== 5) begin failures++; $display("FAIL b2b_sw cycles=%0d required=5 %s", ncyc, trace_msg(nbad)); end
    run_insn(6'h23, 6'h00, 2, 1, ncyc, nbad, nw);
    checks++;
    if (nbad !== 0 || ncyc !== 6) begin failures++; $display("FAIL b2b_lw cycles=%0d required=6 %s", ncyc, trace_msg(nbad)); end
    run_insn(6'h0C, 6'h00, 2, 0, ncyc, nbad, nw);
    checks++;
    if (nbad !== 0 || ncyc !== 4) begin failures++; $display("FAIL b2b_andi cycles=%0d required=4 %s", ncyc, trace_msg(nbad)); end
  endtask

  task automatic test_random();
    int ncyc, nbad, nw;
    logic [5:0] op, fn;
    for (int i = 0; i < 80; i++) begin
      op = legal_ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      fn = legal_fns[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom_range(0, 63));
      run_insn(op, fn, 2, -1, ncyc, nbad, nw);
      checks++;
      if (nbad !== 0) begin failures++; $display("FAIL rand%0d_trace op=%h fn=%h %s", i, op, fn, trace_msg(nbad)); end
      checks++;
      if (ncyc !== spec_cycles(op, fn) + nw)
        begin failures++; $display("FAIL rand%0d_cycles op=%h fn=%h got=%0d required=%0d", i, op, fn, ncyc, spec_cycles(op, fn) + nw); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype_add();
    test_lw_wait();
    test_branch();
    test_jump();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
